alu_ctrl_dmem: RTL and testbench
================================

Name: alu_ctrl_dmem

Overview:
- Execute/memory slice of the single-cycle 8-bit-PC MIPS-like CPU.
- Decodes opcode/funct into datapath controls and selects the ALU B operand (register or sign-extended immediate).
- Computes the ALU result and flags, accesses a 128-word data memory, and produces the register writeback value.
- PC logic, register file and instruction memory sit outside; they consume the control outputs (jump, branch_taken, reg_write, reg_dest).

Parameters:
- DATA_W, 32, datapath width.
- DMEM_DEPTH, 128, data memory words.
- DMEM_AW, 7, data memory address width (log2 DMEM_DEPTH).

Ports:
- clk  input  1  single clock; memory writes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  6  instruction[31:26].
- funct  input  6  instruction[5:0].
- rs_data  input  32  register file read data 1 (ALU A).
- rt_data  input  32  register file read data 2 (ALU B when alu_src=0; memory store data).
- se_imm  input  32  sign-extended instruction[15:0].
- alu_op  output  4  ALU operation code.
- reg_dest, jump, branch, mem_read, mem_write, alu_src, reg_write, mem_to_reg  output  1 each  decoded controls.
- branch_taken  output  1  branch & zero.
- alu_result  output  32  ALU result.
- zero, lt, gt  output  1 each  ALU flags.
- dmem_rdata  output  32  data memory read data.
- wb_data  output  32  mem_to_reg ? dmem_rdata : alu_result.

Behaviour:
- All outputs except memory contents are combinational; the memory array is the only state.
- ALU op codes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT, 1100 NOR. Any other code gives result 0.
- Decode, opcode 0x00 (R-type): reg_dest=1, reg_write=1, alu_src=0. funct maps 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT. Unknown funct: reg_write=0, alu_op=ADD.
- Decode, immediate ops: 0x08 addi → ADD, 0x0A slti → SLT; both alu_src=1, reg_write=1, reg_dest=0.
- Decode, memory ops:
  - 0x23 lw: ADD, alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1.
  - 0x2B sw: ADD, alu_src=1, mem_write=1, reg_write=0.
- Decode, control flow:
  - 0x04 beq: SUB, alu_src=0, branch=1.
  - 0x02 j: jump=1; all other controls 0.
- Unlisted opcode: all controls 0, alu_op=ADD (NOP).
- ALU B = alu_src ? se_imm : rt_data.
- ADD and SUB wrap modulo 2^32; overflow is ignored.
- SLT is signed: result 32'd1 if A<B, else 0.
- zero = (alu_result == 0).
- lt = signed A<B and gt = signed A>B, computed for every op regardless of alu_op.
- Memory: DMEM_DEPTH x DATA_W; address = alu_result[6:0], upper bits ignored (address 128 aliases to 0).
- Read: dmem_rdata = mem[addr] when mem_read=1, else 0. Combinational, same cycle.
- Write: mem[addr] <= rt_data on rising clk when mem_write=1 and rst_n=1.
- Read-during-write to the same address returns old data until the edge; new data is visible afterwards.
- Reset: rst_n low asynchronously clears all memory words to 0 and blocks writes. Combinational outputs keep following their inputs.
- Reset deasserted mid-operation: the first write occurs at the first rising edge with rst_n high.
- mem_read and mem_write never both asserted by the decode.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_J);
  - funct constants;
  - ALU op codes as a 4-bit enum;
  - DATA_W and DMEM_DEPTH defaults.
- Natural sub-modules: alu_ctrl_decode (combinational control), alu_core (ALU + flags), dmem_bank (memory). The top wires them together with the two muxes.

Test Plan:
- rst_n=0 pulse, then lw opcode 0x23 with rs_data=0, se_imm=5 → alu_result=5, mem_read=1, dmem_rdata=0, wb_data=0.
- sw 0x2B with rs_data=4, se_imm=3, rt_data=0xDEADBEEF, clock edge → then lw to address 7 → dmem_rdata=0xDEADBEEF, wb_data=0xDEADBEEF, reg_write=1.
- R-type funct 0x22 with A=10, B=10 → alu_result=0, zero=1, lt=0, gt=0. Then beq (0x04), same operands → branch_taken=1.
- R-type funct 0x2A with A=0xFFFFFFFF, B=1 → alu_result=1, lt=1. Funct 0x20 with A=0xFFFFFFFF, B=1 → alu_result=0, zero=1 (wrap).
- Jump 0x02 → jump=1, reg_write=mem_write=0. Unknown opcode 0x3F → all controls 0. Store to address 0x80 (alu_result=128) → aliases to word 0.
- rst_n asserted low between clock edges after a store → memory word reads 0 immediately. A write with mem_write=1 while rst_n=0 is ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, functs, ALU op codes and datapath defaults.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int DMEM_DEPTH = 128;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_e;
endpackage

// File: rtl/alu_core.sv
// alu_core: ALU result plus zero and signed compare flags.
module alu_core
  import cpu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  alu_op_e      op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         lt,
  output logic         gt
);
  always_comb begin
    case (op)
      ALU_AND: result = a & b;
      ALU_OR: result = a | b;
      ALU_ADD: result = a + b;
      ALU_XOR: result = a ^ b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = W'(lt);
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end
  assign zero = result == '0;
  assign lt = $signed(a) < $signed(b);
  assign gt = $signed(a) > $signed(b);
endmodule

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: opcode/funct to datapath control signals.
module alu_ctrl_decode
  import cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_op_e    alu_op,
  output logic       reg_dest,
  output logic       jump,
  output logic       branch,
  output logic       mem_read,
  output logic       mem_write,
  output logic       alu_src,
  output logic       reg_write,
  output logic       mem_to_reg
);
  always_comb begin
    alu_op = ALU_ADD;
    reg_dest = 1'b0;
    jump = 1'b0;
    branch = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    alu_src = 1'b0;
    reg_write = 1'b0;
    mem_to_reg = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reg_dest = 1'b1;
        reg_write = 1'b1;
        case (funct)
          FN_ADD: alu_op = ALU_ADD;
          FN_SUB: alu_op = ALU_SUB;
          FN_AND: alu_op = ALU_AND;
          FN_OR: alu_op = ALU_OR;
          FN_XOR: alu_op = ALU_XOR;
          FN_NOR: alu_op = ALU_NOR;
          FN_SLT: alu_op = ALU_SLT;
          default: reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        alu_src = 1'b1;
        reg_write = 1'b1;
      end
      OP_SLTI: begin
        alu_op = ALU_SLT;
        alu_src = 1'b1;
        reg_write = 1'b1;
      end
      OP_LW: begin
        alu_src = 1'b1;
        mem_read = 1'b1;
        mem_to_reg = 1'b1;
        reg_write = 1'b1;
      end
      OP_SW: begin
        alu_src = 1'b1;
        mem_write = 1'b1;
      end
      OP_BEQ: begin
        alu_op = ALU_SUB;
        branch = 1'b1;
      end
      OP_J: jump = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/dmem_bank.sv
// dmem_bank: word memory, combinational read, clocked write, async clear.
module dmem_bank
  import cpu_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic          re,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end
  assign rdata = re ? mem[addr] : '0;
endmodule

// File: rtl/alu_ctrl_dmem.sv
// alu_ctrl_dmem: execute/memory slice, decode + ALU + data memory + writeback mux.
module alu_ctrl_dmem
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int DMEM_DEPTH = cpu_pkg::DMEM_DEPTH,
  parameter int DMEM_AW = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] se_imm,
  output logic [3:0]        alu_op,
  output logic              reg_dest,
  output logic              jump,
  output logic              branch,
  output logic              mem_read,
  output logic              mem_write,
  output logic              alu_src,
  output logic              reg_write,
  output logic              mem_to_reg,
  output logic              branch_taken,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  output logic              lt,
  output logic              gt,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] wb_data
);
  alu_op_e op;
  alu_ctrl_decode u_dec (
    .opcode(opcode), .funct(funct), .alu_op(op), .reg_dest(reg_dest), .jump(jump),
    .branch(branch), .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg)
  );
  alu_core #(.W(DATA_W)) u_alu (
    .op(op), .a(rs_data), .b(alu_src ? se_imm : rt_data), .result(alu_result),
    .zero(zero), .lt(lt), .gt(gt)
  );
  // Upper address bits are dropped so addresses alias modulo the depth.
  dmem_bank #(.W(DATA_W), .DEPTH(DMEM_DEPTH), .AW(DMEM_AW)) u_mem (
    .clk(clk), .rst_n(rst_n), .addr(alu_result[DMEM_AW-1:0]), .we(mem_write),
    .re(mem_read), .wdata(rt_data), .rdata(dmem_rdata)
  );
  assign alu_op = op;
  assign branch_taken = branch & zero;
  assign wb_data = mem_to_reg ? dmem_rdata : alu_result;
endmodule

// File: tb/tb_alu_ctrl_dmem.sv
// tb_alu_ctrl_dmem: directed plus random checks against a behavioural model.
module tb_alu_ctrl_dmem;
  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] opcode, funct;
  logic [31:0] rs_data, rt_data, se_imm;
  logic [3:0] alu_op;
  logic reg_dest, jump, branch, mem_read, mem_write, alu_src, reg_write, mem_to_reg;
  logic branch_taken, zero, lt, gt;
  logic [31:0] alu_result, dmem_rdata, wb_data;
  int tests = 0;
  int fails = 0;
  logic [31:0] mem_m [128];
  logic exp_we;
  logic [6:0] exp_addr;
  logic [31:0] exp_wd;

  always #5 clk = ~clk;

  alu_ctrl_dmem dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .rs_data(rs_data),
    .rt_data(rt_data), .se_imm(se_imm), .alu_op(alu_op), .reg_dest(reg_dest), .jump(jump),
    .branch(branch), .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .branch_taken(branch_taken),
    .alu_result(alu_result), .zero(zero), .lt(lt), .gt(gt), .dmem_rdata(dmem_rdata),
    .wb_data(wb_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_rst(input logic v);
    rst_n = v;
    if (!v) for (int i = 0; i < 128; i++) mem_m[i] = '0;
  endtask

  // Drive one instruction and compare every output against the model.
  task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] rt, input logic [31:0] imm);
    logic [3:0] e_op;
    logic e_rd, e_j, e_br, e_mr, e_mw, e_src, e_rw, e_m2r, e_lt, e_gt;
    logic [31:0] b, res, rd;
    opcode = op; funct = fn; rs_data = a; rt_data = rt; se_imm = imm;
    {e_rd, e_j, e_br, e_mr, e_mw, e_src, e_rw, e_m2r} = '0;
    e_op = 4'h2;
    if (op == 6'h00) begin
      e_rd = 1; e_rw = 1;
      case (fn)
        6'h20: e_op = 4'h2;
        6'h22: e_op = 4'h6;
        6'h24: e_op = 4'h0;
        6'h25: e_op = 4'h1;
        6'h26: e_op = 4'h3;
        6'h27: e_op = 4'hC;
        6'h2A: e_op = 4'h7;
        default: e_rw = 0;
      endcase
    end else if (op == 6'h08) begin e_src = 1; e_rw = 1; end
    else if (op == 6'h0A) begin e_op = 4'h7; e_src = 1; e_rw = 1; end
    else if (op == 6'h23) begin e_src = 1; e_mr = 1; e_m2r = 1; e_rw = 1; end
    else if (op == 6'h2B) begin e_src = 1; e_mw = 1; end
    else if (op == 6'h04) begin e_op = 4'h6; e_br = 1; end
    else if (op == 6'h02) e_j = 1;
    b = e_src ? imm : rt;
    e_lt = $signed(a) < $signed(b);
    e_gt = $signed(a) > $signed(b);
    case (e_op)
      4'h0: res = a & b;
      4'h1: res = a | b;
      4'h2: res = a + b;
      4'h3: res = a ^ b;
      4'h6: res = a - b;
      4'h7: res = {31'd0, e_lt};
      4'hC: res = ~(a | b);
      default: res = 0;
    endcase
    rd = e_mr ? mem_m[res % 128] : 32'd0;
    exp_we = e_mw; exp_addr = 7'(res % 128); exp_wd = rt;
    #1;
    check("alu_op", {28'd0, alu_op}, {28'd0, e_op});
    check("ctrl", {24'd0, reg_dest, jump, branch, mem_read, mem_write, alu_src, reg_write, mem_to_reg},
          {24'd0, e_rd, e_j, e_br, e_mr, e_mw, e_src, e_rw, e_m2r});
    check("alu_result", alu_result, res);
    check("flags", {28'd0, branch_taken, zero, lt, gt},
          {28'd0, e_br && res == 0, res == 0, e_lt, e_gt});
    check("dmem_rdata", dmem_rdata, rd);
    check("wb_data", wb_data, e_m2r ? rd : res);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n && exp_we) mem_m[exp_addr] = exp_wd;
    @(negedge clk);
  endtask

  logic [5:0] ops [8] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0A, 6'h23, 6'h2B, 6'h3F};
  logic [5:0] fns [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h11};

  initial begin
    set_rst(1'b0);
    opcode = 0; funct = 0; rs_data = 0; rt_data = 0; se_imm = 0;
    #12 set_rst(1'b1);
    @(negedge clk);
    apply(6'h23, 0, 0, 0, 5);
    check("tp_lw_res", alu_result, 5);
    check("tp_lw_rd", dmem_rdata, 0);
    tick();
    apply(6'h2B, 0, 4, 32'hDEADBEEF, 3); tick();
    apply(6'h23, 0, 0, 0, 7);
    check("tp_lw7", wb_data, 32'hDEADBEEF);
    check("tp_lw7_rw", {31'd0, reg_write}, 1);
    tick();
    apply(6'h00, 6'h22, 10, 10, 0);
    check("tp_sub_zero", {31'd0, zero}, 1);
    tick();
    apply(6'h04, 0, 10, 10, 0);
    check("tp_beq_taken", {31'd0, branch_taken}, 1);
    tick();
    apply(6'h00, 6'h2A, 32'hFFFFFFFF, 1, 0);
    check("tp_slt", alu_result, 1);
    tick();
    apply(6'h00, 6'h20, 32'hFFFFFFFF, 1, 0);
    check("tp_add_wrap", alu_result, 0);
    tick();
    apply(6'h02, 0, 3, 4, 5);
    check("tp_jump", {31'd0, jump}, 1);
    tick();
    apply(6'h3F, 6'h20, 3, 4, 5); tick();
    apply(6'h2B, 0, 32'h80, 32'h12345678, 0); tick();
    apply(6'h23, 0, 0, 0, 0);
    check("tp_alias", dmem_rdata, 32'h12345678);
    #2 set_rst(1'b0);
    #1 check("tp_rst_clear", dmem_rdata, 0);
    @(negedge clk);
    apply(6'h2B, 0, 0, 32'hCAFEF00D, 0); tick();
    set_rst(1'b1);
    apply(6'h23, 0, 0, 0, 0);
    check("tp_rst_nowrite", dmem_rdata, 0);
    tick();
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, imm;
      a = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 300);
      imm = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 20);
      apply($urandom_range(0, 5) == 0 ? 6'($urandom) : ops[$urandom_range(0, 7)],
            fns[$urandom_range(0, 7)], a, $urandom, imm);
      if ($urandom_range(0, 59) == 0) begin
        set_rst(1'b0);
        tick();
        set_rst(1'b1);
      end else tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
